// File: rtl/led_pkg.sv
// Shared definitions for the LED arbiter: FSM encoding, default timing constants
// and the rotating-priority pick used in IDLE.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned NUM_REQ             = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 60000;    // 10 ms at 6 MHz
  localparam int unsigned HOLD_CYCLES_DEF     = 3000000;  // 0.5 s at 6 MHz
  localparam int unsigned GAP_CYCLES_DEF      = 600000;   // 0.1 s at 6 MHz

  // First set request scanning ptr, ptr+1, ... modulo 4 (scan runs backwards so
  // the earliest hit in rotation order is the one left standing).
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer into a stable-level debouncer; req is the
// accepted level inverted (pressed = 1).
module btn_debounce
  import led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic req
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // cnt counts consecutive cycles where the synchronized level differs from the
  // accepted one; any return to the accepted level clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign req = ~stable;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter granting one of four debounced buttons a timed LED slot.
//   state | meaning
//   IDLE  | LEDs dark, arbitrate among pending requests this cycle
//   GRANT | owner's LED lit for HOLD_CYCLES cycles, requests ignored
//   GAP   | all LEDs dark for GAP_CYCLES cycles before the next arbitration
module led_arbiter
  import led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES      = GAP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_n,
  output logic [3:0] led,
  output logic [1:0] grant_id,
  output logic       busy
);

  logic [3:0]  req;
  logic [1:0]  ptr;
  logic [1:0]  sel;
  logic [31:0] cnt;
  state_t      state;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .rst_n(rst_n),
      .btn_n(btn_n[i]),
      .req  (req[i])
    );
  end

  assign sel = rr_pick(req, ptr);

  // cnt is shared by GRANT and GAP and runs from the loaded length down to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      led      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            grant_id <= sel;
            led      <= 4'b0001 << sel;
            busy     <= 1'b1;
            cnt      <= 32'(HOLD_CYCLES);
          end
        end
        GRANT: begin
          if (cnt <= 32'd1) begin
            state <= GAP;
            led   <= '0;
            ptr   <= grant_id + 2'd1;
            cnt   <= 32'(GAP_CYCLES);
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        GAP: begin
          if (cnt <= 32'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          led   <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
